reboot_ctrl: RTL

REBOOT_CTRL -- requirements
Module: reboot_ctrl

---
 rtl/boot_pkg.sv | 40 ++++
 rtl/sync_2ff.sv | 33 +++
 rtl/reboot_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the warm-reboot controller: bus register indices,
// unlock key bytes, reset constants and the controller state encoding.
// The state encoding is visible to software through STATUS[2:0], so the
// numeric values are part of the register interface.
// ---------------------------------------------------------------------------
package boot_pkg;

  // Word register indices on the memory-mapped bus
  localparam logic [3:0] REG_ADDR   = 4'h0;
  localparam logic [3:0] REG_KEY    = 4'h1;
  localparam logic [3:0] REG_CTRL   = 4'h2;
  localparam logic [3:0] REG_DELAY  = 4'h3;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_ERRCLR = 4'h5;

  // Two-step unlock sequence written to KEY
  localparam logic [7:0] KEY_UNLOCK = 8'h5A;
  localparam logic [7:0] KEY_ARM    = 8'hA5;

  localparam logic [15:0] DELAY_RESET = 16'h0100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UNLK  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DELAY = 3'd3,
    ST_FIRE  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } boot_state_e;

  // A key only matches when the full word equals the zero-extended key byte,
  // so stray upper bits never unlock the controller.
  function automatic logic key_match(input logic [31:0] data, input logic [7:0] key);
    return (data == {24'h000000, key});
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing a single asynchronous level into the
// mem_clk domain.
//   mem_clk : destination clock
//   rst_n   : asynchronous active-low reset, both flops clear to 0
//   d_i     : asynchronous input level
//   q_o     : synchronized level (two mem_clk cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic mem_clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability chain: first flop may go metastable, second one resolves it
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reboot_ctrl.sv
// ---------------------------------------------------------------------------
// reboot_ctrl
// Software-controlled warm-reboot requester. Software loads a flash address,
// unlocks with a two-word key sequence, then writes GO. After a programmable
// delay the controller raises reboot towards the ICAP sequencer and waits
// for its acknowledge (rising edge of icap_busy). A missing acknowledge
// raises a sticky error interrupt.
//   mem_clk, rst_n          : clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb : zero-wait-state register bus (full-word writes)
//   mem_ready, mem_rdata    : access complete, read data (0 when idle)
//   icap_busy               : asynchronous acknowledge from the ICAP domain
//   spi_addr                : registered warm-boot flash address
//   reboot                  : registered reboot request level
//   irq                     : level interrupt mirroring the sticky error flag
// ---------------------------------------------------------------------------
module reboot_ctrl
  import boot_pkg::*;
#(
  parameter logic [23:0] DEFAULT_ADDR = 24'h080000,
  parameter int          ACK_TIMEOUT  = 1024
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        icap_busy,
  output logic [23:0] spi_addr,
  output logic        reboot,
  output logic        irq
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  boot_state_e      state_q, state_d;
  logic [15:0]      dcnt_q, dcnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [23:0]      addr_q;
  logic [15:0]      delay_q;
  logic             err_q, err_d;
  logic             reboot_q, reboot_d;
  logic             busy_prev_q;

  logic busy_sync_s;
  logic ack_s;
  logic locked_s;
  logic wr_s;
  logic key_wr_s;
  logic go_wr_s;
  logic errclr_s;
  logic addr_wr_s;
  logic delay_wr_s;

  sync_2ff u_busy_sync (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .d_i     (icap_busy),
    .q_o     (busy_sync_s)
  );

  // Acknowledge is the rising edge of the synchronized busy level
  assign ack_s = busy_sync_s & ~busy_prev_q;

  assign locked_s   = (state_q != ST_IDLE);
  assign wr_s       = mem_valid & (&mem_wstrb);
  assign key_wr_s   = wr_s & (mem_addr == REG_KEY);
  assign go_wr_s    = wr_s & (mem_addr == REG_CTRL) & mem_wdata[0];
  assign errclr_s   = wr_s & (mem_addr == REG_ERRCLR);
  assign addr_wr_s  = wr_s & (mem_addr == REG_ADDR) & ~locked_s;
  assign delay_wr_s = wr_s & (mem_addr == REG_DELAY) & ~locked_s;

  // State and sequencing counters
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dcnt_q  <= 16'h0000;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic; any KEY write aborts before firing, and the abort is
  // checked ahead of the delay terminal count so it wins a same-cycle tie.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (key_wr_s && key_match(mem_wdata, KEY_UNLOCK)) begin
          state_d = ST_UNLK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UNLK: begin
        if (key_wr_s) begin
          if (key_match(mem_wdata, KEY_ARM)) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_UNLK;
        end
      end
      ST_ARMED: begin
        if (key_wr_s) begin
          state_d = ST_IDLE;
        end else if (go_wr_s) begin
          state_d = ST_DELAY;
          dcnt_d  = delay_q;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_DELAY: begin
        if (key_wr_s) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == 16'h0000) begin
          state_d = ST_FIRE;
          tmo_d   = '0;
        end else begin
          dcnt_d = dcnt_q - 16'h0001;
        end
      end
      ST_FIRE: begin
        // Acknowledge checked first so one arriving in the last cycle still succeeds
        if (ack_s) begin
          state_d = ST_DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; reboot is derived from the next state so the registered
  // level tracks FIRE/DONE exactly, and error set dominates clear.
  always_comb begin
    reboot_d = (state_d == ST_FIRE) || (state_d == ST_DONE);
    if (state_q == ST_ERROR) begin
      err_d = 1'b1;
    end else if (errclr_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Software-visible registers, registered outputs and edge-detect history
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= DEFAULT_ADDR;
      delay_q     <= DELAY_RESET;
      err_q       <= 1'b0;
      reboot_q    <= 1'b0;
      busy_prev_q <= 1'b0;
    end else begin
      if (addr_wr_s) begin
        addr_q <= mem_wdata[23:0];
      end
      if (delay_wr_s) begin
        delay_q <= mem_wdata[15:0];
      end
      err_q       <= err_d;
      reboot_q    <= reboot_d;
      busy_prev_q <= busy_sync_s;
    end
  end

  // Zero-wait-state read mux; idle bus reads as zero
  always_comb begin
    mem_rdata = 32'h0000_0000;
    if (mem_valid) begin
      case (mem_addr)
        REG_ADDR:   mem_rdata = {8'h00, addr_q};
        REG_DELAY:  mem_rdata = {16'h0000, delay_q};
        REG_STATUS: mem_rdata = {22'h000000, locked_s, err_q, 5'h00, state_q};
        default:    mem_rdata = 32'h0000_0000;
      endcase
    end else begin
      mem_rdata = 32'h0000_0000;
    end
  end

  assign mem_ready = mem_valid;
  assign spi_addr  = addr_q;
  assign reboot    = reboot_q;
  assign irq       = err_q;

endmodule
